// File: rtl/qpsk_pkg.sv
// qpsk_pkg: definitions shared by the QPSK transmitter (qpsk_tx) and the
// demapper/loopback checker.
//   SYMS_PER_BYTE / BITS_PER_SYM : framing of one character into symbols
//   SYNC_CHAR                    : preamble character (used when
//                                  QPSK_TX_PREAMBLE_EN is defined)
//   tx_state_e                   : transmitter sequencing states
//   map_bit()                    : bit -> signed level (0 -> +amp, 1 -> -amp)
package qpsk_pkg;

  localparam int unsigned SYMS_PER_BYTE = 4;
  localparam int unsigned BITS_PER_SYM  = 2;
  localparam logic [7:0]  SYNC_CHAR     = 8'h7E;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  function automatic logic signed [7:0] map_bit(input logic b, input logic signed [7:0] amp);
    return b ? -amp : amp;
  endfunction

endpackage

// File: rtl/qpsk_tx_pacer.sv
// qpsk_tx_pacer: symbol pacing down-counter.
//   clk      in  system clock
//   reset    in  synchronous active-high reset (counter -> 0, expired)
//   load     in  restart the interval: counter <= SYM_PERIOD-1
//   clear    in  force the counter expired (takes priority over load)
//   expired  out counter is zero; a symbol may be emitted this cycle
// The counter decrements to zero and rests there, so with SYM_PERIOD=1 a
// load leaves it expired and strobes can run back-to-back.
module qpsk_tx_pacer #(
  parameter int unsigned SYM_PERIOD = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int unsigned    CW     = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam logic [CW-1:0]  RELOAD = CW'(SYM_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/qpsk_tx.sv
// qpsk_tx: QPSK transmitter / mapper. Each accepted 8-bit character is sent
// as 4 symbols, LSB pair first; in each pair the low bit drives I and the
// high bit drives Q, bit 0 -> +AMP, bit 1 -> -AMP.
//   clk        in   system clock (posedge)
//   reset      in   synchronous active-high reset; aborts a byte in flight
//   data       in   character to transmit
//   data_valid in   data holds a valid character
//   data_ready out  a character can be accepted this cycle
//   sym_i      out  signed I level (holds while iq_valid=0)
//   sym_q      out  signed Q level (holds while iq_valid=0)
//   iq_valid   out  single-cycle strobe marking a new symbol
//   busy       out  hold register or shifter occupied
// Parameters: AMP (1..127) symbol magnitude, SYM_PERIOD (>=1) cycles
// between strobes.
// Optional: define QPSK_TX_PREAMBLE_EN to send SYNC_CHAR after every reset
// before any data is accepted.
module qpsk_tx
  import qpsk_pkg::*;
#(
  parameter int          AMP        = 100,
  parameter int unsigned SYM_PERIOD = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] sym_i,
  output logic [7:0] sym_q,
  output logic       iq_valid,
  output logic       busy
);

  localparam logic signed [7:0] AMP8     = 8'(AMP);
  localparam logic [1:0]        LAST_SYM = 2'(SYMS_PER_BYTE - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] sym_cnt_q, sym_cnt_d;
  logic [7:0] sym_i_q, sym_i_d;
  logic [7:0] sym_q_q, sym_q_d;
  logic       iq_valid_q, iq_valid_d;
  logic       rdy_en_q;
`ifdef QPSK_TX_PREAMBLE_EN
  logic       pre_q, pre_d;
`endif

  logic accept;
  logic hold_take;
  logic pacer_load;
  logic pacer_clear;
  logic pacer_expired;

  qpsk_tx_pacer #(
    .SYM_PERIOD (SYM_PERIOD)
  ) u_pacer (
    .clk     (clk),
    .reset   (reset),
    .load    (pacer_load),
    .clear   (pacer_clear),
    .expired (pacer_expired)
  );

  // rdy_en_q keeps data_ready low while reset is held.
`ifdef QPSK_TX_PREAMBLE_EN
  assign data_ready = rdy_en_q && !hold_full_q && !pre_q;
`else
  assign data_ready = rdy_en_q && !hold_full_q;
`endif
  assign accept = data_valid && data_ready;
  assign busy   = hold_full_q || (state_q != TX_IDLE);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    sym_cnt_d   = sym_cnt_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    iq_valid_d  = 1'b0;
    hold_take   = 1'b0;
    pacer_load  = 1'b0;
    pacer_clear = 1'b0;
`ifdef QPSK_TX_PREAMBLE_EN
    pre_d       = pre_q;
`endif

    case (state_q)
      TX_IDLE: begin
`ifdef QPSK_TX_PREAMBLE_EN
        if (pre_q) begin
          shift_d     = SYNC_CHAR;
          sym_cnt_d   = '0;
          pacer_clear = 1'b1;
          state_d     = TX_SEND;
        end else
`endif
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_take   = 1'b1;
          sym_cnt_d   = '0;
          pacer_clear = 1'b1;
          state_d     = TX_SEND;
        end
      end
      TX_SEND: begin
        if (pacer_expired) begin
          sym_i_d    = map_bit(shift_q[0], AMP8);
          sym_q_d    = map_bit(shift_q[1], AMP8);
          iq_valid_d = 1'b1;
          pacer_load = 1'b1;
          shift_d    = shift_q >> BITS_PER_SYM;
          sym_cnt_d  = sym_cnt_q + 2'd1;
          if (sym_cnt_q == LAST_SYM) begin
`ifdef QPSK_TX_PREAMBLE_EN
            pre_d = 1'b0;
`endif
            // Chain straight into the next byte; sym_cnt wraps to 0 and the
            // pacer keeps running, so the inter-byte gap is SYM_PERIOD.
            if (hold_full_q) begin
              shift_d   = hold_q;
              hold_take = 1'b1;
            end else begin
              state_d = TX_IDLE;
            end
          end
        end
      end
    endcase

    // A new byte may land in hold on the same edge that hold is drained.
    if (accept) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end else if (hold_take) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      sym_cnt_q   <= '0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      iq_valid_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
`ifdef QPSK_TX_PREAMBLE_EN
      pre_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      sym_cnt_q   <= sym_cnt_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      iq_valid_q  <= iq_valid_d;
      rdy_en_q    <= 1'b1;
`ifdef QPSK_TX_PREAMBLE_EN
      pre_q       <= pre_d;
`endif
    end
  end

  assign sym_i    = sym_i_q;
  assign sym_q    = sym_q_q;
  assign iq_valid = iq_valid_q;

endmodule

// File: tb/tb_qpsk_tx.sv
// Testbench for qpsk_tx: two instances (SYM_PERIOD=1 and SYM_PERIOD=3,
// AMP=100), directed vector table, back-to-back, mid-byte reset and a
// randomized stream checked against a symbol-queue reference model.
module tb_qpsk_tx;

  localparam int AMP = 100;

  logic       clk;
  logic       reset;
  logic [7:0] dat  [2];
  logic       dv   [2];
  logic       dr   [2];
  logic [7:0] si   [2];
  logic [7:0] sq   [2];
  logic       ivld [2];
  logic       bsy  [2];

  qpsk_tx #(.AMP(AMP), .SYM_PERIOD(1)) u_dut1 (
    .clk(clk), .reset(reset), .data(dat[0]), .data_valid(dv[0]), .data_ready(dr[0]),
    .sym_i(si[0]), .sym_q(sq[0]), .iq_valid(ivld[0]), .busy(bsy[0])
  );

  qpsk_tx #(.AMP(AMP), .SYM_PERIOD(3)) u_dut3 (
    .clk(clk), .reset(reset), .data(dat[1]), .data_valid(dv[1]), .data_ready(dr[1]),
    .sym_i(si[1]), .sym_q(sq[1]), .iq_valid(ivld[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         ei [4];
    int         eq [4];
  } vec_t;

  vec_t vt [6];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  int         expq  [2][$];
  int         sidx  [2];
  int         last  [2];
  logic [7:0] rxb   [2];
  logic [7:0] rxq   [2][$];

  // capture buffers
  int   ncap;
  int   cap_c [16];
  int   cap_i [16];
  int   cap_q [16];
  logic dr_log [32];

  function automatic int per(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected symbols of a byte, straight from the mapping rule.
  task automatic push_byte(input int k, input logic [7:0] b);
    for (int j = 0; j < 4; j++) begin
      int pair = (int'(b) >> (2 * j)) & 3;
      int iv = ((pair & 1) != 0) ? -AMP : AMP;
      int qv = ((pair & 2) != 0) ? -AMP : AMP;
      expq[k].push_back(((iv & 255) << 8) | (qv & 255));
    end
  endtask

  // One negedge: run the model/scoreboard for both instances.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        expq[k].delete();
        sidx[k] = 0;
        rxb[k]  = '0;
`ifdef QPSK_TX_PREAMBLE_EN
        push_byte(k, 8'h7E);
`endif
      end else begin
        if (ivld[k]) begin
          int got = int'({si[k], sq[k]});
          if (expq[k].size() == 0) begin
            chk($sformatf("extra_strobe%0d", k), got, -1);
          end else begin
            chk($sformatf("sym_value%0d", k), got, expq[k].pop_front());
          end
          if ((sidx[k] % 4) != 0) chk($sformatf("sym_gap%0d", k), cyc - last[k], per(k));
          last[k] = cyc;
          rxb[k] = rxb[k] | (8'({sq[k][7], si[k][7]}) << (2 * (sidx[k] % 4)));
          if ((sidx[k] % 4) == 3) begin
            rxq[k].push_back(rxb[k]);
            rxb[k] = '0;
          end
          sidx[k]++;
        end
        if (dv[k] && dr[k]) push_byte(k, dat[k]);
      end
    end
  endtask

  task automatic wait_accept(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (dr[k]) ok = 1'b1;
    end
    chk($sformatf("accept_timeout%0d", k), int'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (!bsy[k] && expq[k].size() == 0) ok = 1'b1;
    end
    chk($sformatf("idle_timeout%0d", k), int'(ok), 1);
    @(posedge clk); #1;
  endtask

  // c counts negedges after the accept edge (c=0 is the first one).
  task automatic capture(input int k, input int ncyc);
    bit drop;
    ncap = 0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      dr_log[c] = dr[k];
      if (ivld[k] && ncap < 16) begin
        cap_c[ncap] = c;
        cap_i[ncap] = int'($signed(si[k]));
        cap_q[ncap] = int'($signed(sq[k]));
        ncap++;
      end
      drop = dv[k] && dr[k];
      @(posedge clk); #1;
      if (drop) dv[k] = 1'b0;
    end
  endtask

  task automatic check_caps(input int k, input int vi, input int first, input int base);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("v%0d_k%0d_t%0d", vi, k, j), cap_c[base + j], first + j * per(k));
      chk($sformatf("v%0d_k%0d_i%0d", vi, k, j), cap_i[base + j], vt[vi].ei[j]);
      chk($sformatf("v%0d_k%0d_q%0d", vi, k, j), cap_q[base + j], vt[vi].eq[j]);
    end
  endtask

  task automatic run_vec(input int k, input int vi);
    wait_idle(k);
    dv[k]  = 1'b1;
    dat[k] = vt[vi].data;
    wait_accept(k);
    dv[k]  = 1'b0;
    capture(k, 2 + 3 * per(k) + 4);
    chk($sformatf("v%0d_k%0d_count", vi, k), ncap, 4);
    if (ncap == 4) check_caps(k, vi, 2, 0);
  endtask

  task automatic after_release();
`ifdef QPSK_TX_PREAMBLE_EN
    capture(0, 12);
    chk("pre_count", ncap, 4);
    if (ncap == 4) check_caps(0, 3, 1, 0);
    for (int c = 0; c < 4; c++) chk($sformatf("pre_ready%0d", c), int'(dr_log[c]), 0);
    chk("pre_ready_rise", int'(dr_log[4]), 1);
`else
    tick();
    chk("ready_after_rst0", int'(dr[0]), 1);
    chk("ready_after_rst1", int'(dr[1]), 1);
    chk("busy_after_rst0", int'(bsy[0]), 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] list [2][$];
    int n [2];
    int base [2];
    bit acc [2];
    string hello = "Hello";
    int ns;

    vt[0].data = 8'h41; vt[0].ei = '{-100, 100, 100, -100}; vt[0].eq = '{100, 100, 100, 100};
    vt[1].data = 8'h00; vt[1].ei = '{100, 100, 100, 100};   vt[1].eq = '{100, 100, 100, 100};
    vt[2].data = 8'hFF; vt[2].ei = '{-100, -100, -100, -100}; vt[2].eq = '{-100, -100, -100, -100};
    vt[3].data = 8'h7E; vt[3].ei = '{100, -100, -100, -100}; vt[3].eq = '{-100, -100, -100, 100};
    vt[4].data = 8'h55; vt[4].ei = '{-100, -100, -100, -100}; vt[4].eq = '{100, 100, 100, 100};
    vt[5].data = 8'h31; vt[5].ei = '{-100, 100, -100, 100};  vt[5].eq = '{100, 100, -100, 100};

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dv[k] = 1'b0; dat[k] = '0; sidx[k] = 0; last[k] = 0; rxb[k] = '0;
    end
    for (int i = 0; i < 3; i++) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_sym_i%0d", k), int'(si[k]), 0);
      chk($sformatf("rst_sym_q%0d", k), int'(sq[k]), 0);
      chk($sformatf("rst_iq_valid%0d", k), int'(ivld[k]), 0);
      chk($sformatf("rst_ready%0d", k), int'(dr[k]), 0);
      chk($sformatf("rst_busy%0d", k), int'(bsy[k]), 0);
    end
    reset = 1'b0;
    after_release();

    // directed table on both pacing settings
    for (int k = 0; k < 2; k++)
      for (int vi = 0; vi < 6; vi++) run_vec(k, vi);

    // back-to-back 0x00 then 0xFF, SYM_PERIOD=1
    begin
      logic exp_dr [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      wait_idle(0);
      dv[0] = 1'b1; dat[0] = 8'h00;
      wait_accept(0);
      dat[0] = 8'hFF;
      capture(0, 12);
      chk("b2b_count", ncap, 8);
      if (ncap == 8) begin
        check_caps(0, 1, 2, 0);
        check_caps(0, 2, 6, 4);
      end
      for (int c = 0; c < 7; c++) chk($sformatf("b2b_ready%0d", c), int'(dr_log[c]), int'(exp_dr[c]));
    end

    // reset after the 2nd symbol of 0x55
    wait_idle(0);
    dv[0] = 1'b1; dat[0] = 8'h55;
    wait_accept(0);
    dv[0] = 1'b0;
    ns = 0;
    for (int i = 0; i < 20 && ns < 2; i++) begin
      tick();
      if (ivld[0]) ns++;
    end
    chk("midrst_strobes", ns, 2);
    reset = 1'b1;
    tick();
    chk("midrst_iq_valid", int'(ivld[0]), 0);
    chk("midrst_sym_i", int'(si[0]), 0);
    chk("midrst_sym_q", int'(sq[0]), 0);
    chk("midrst_busy", int'(bsy[0]), 0);
    chk("midrst_ready", int'(dr[0]), 0);
    reset = 1'b0;
    after_release();
    run_vec(0, 5);

    // randomized streams: "Hello"+random on SYM_PERIOD=3, random on SYM_PERIOD=1
    wait_idle(0);
    wait_idle(1);
    for (int i = 0; i < hello.len(); i++) list[1].push_back(hello[i]);
    for (int i = 0; i < 15; i++) list[1].push_back(8'($urandom));
    for (int i = 0; i < 24; i++) list[0].push_back(8'($urandom));
    for (int k = 0; k < 2; k++) begin
      n[k] = 0;
      base[k] = rxq[k].size();
    end
    for (int t = 0; t < 4000 && (n[0] < list[0].size() || n[1] < list[1].size()); t++) begin
      tick();
      for (int k = 0; k < 2; k++) acc[k] = dv[k] && dr[k];
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) n[k]++;
        if (n[k] < list[k].size()) begin
          dat[k] = list[k][n[k]];
          dv[k]  = (k == 0) ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
        end else begin
          dv[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stream_sent%0d", k), n[k], list[k].size());
      wait_idle(k);
      chk($sformatf("stream_left%0d", k), expq[k].size(), 0);
      chk($sformatf("stream_rx_count%0d", k), rxq[k].size() - base[k], list[k].size());
      for (int i = 0; i < list[k].size() && base[k] + i < rxq[k].size(); i++)
        chk($sformatf("stream_rx%0d_%0d", k, i), int'(rxq[k][base[k] + i]), int'(list[k][i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
